// File: rtl/div_unit_pkg.sv
// Shared CPU defines for the divider: FSM state encoding and default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_unit_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// Combinational restoring shift-subtract chain resolving BITS_PER_CYCLE quotient bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the outputs.
//
// Ports:
//   rem_in / rem_out : partial remainder before/after the chain (always < divisor)
//   quo_in / quo_out : dividend bits shifting out the top, quotient bits shifting in the bottom
//   divisor          : divisor magnitude
module div_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH:0]   trial;
   logic             ge;

   always_comb begin
      r     = rem_in;
      q     = quo_in;
      trial = '0;
      ge    = 1'b0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         // Remainder stays below the divisor, so the shifted trial needs one extra bit.
         trial = {r, q[WIDTH-1]};
         ge    = (trial >= {1'b0, divisor});
         if (ge) begin
            r = WIDTH'(trial - {1'b0, divisor});
         end else begin
            r = trial[WIDTH-1:0];
         end
         q = {q[WIDTH-2:0], ge};
      end
      rem_out = r;
      quo_out = q;
   end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned integer divider (DIV/DIVU) with cancel.
// Latency: WIDTH/BITS_PER_CYCLE+1 cycles start-to-valid; 1 cycle for divide-by-zero.
// Backpressure: busy stalls the pipeline while running; start outside IDLE is dropped.
//
// Ports:
//   clk, rst (sync, active-low), start, signed_i, a (dividend), b (divisor), cancel
//   busy (stall request), valid (one-cycle result pulse), quotient, remainder, div_by_zero
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH          = DEFAULT_WIDTH,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvsr_r;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic             q_neg;
   logic             r_neg;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;

   // Magnitudes: the most-negative value maps to itself, which is its correct unsigned magnitude.
   assign a_neg = signed_i & a[WIDTH-1];
   assign b_neg = signed_i & b[WIDTH-1];
   assign a_abs = a_neg ? -a : a;
   assign b_abs = b_neg ? -b : b;

   assign busy = (state == RUN) | ((state == IDLE) & start & ~cancel);

   div_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .rem_in  (rem_r),
      .quo_in  (quo_r),
      .divisor (dvsr_r),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         valid       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         rem_r       <= '0;
         quo_r       <= '0;
         dvsr_r      <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
      end else if (cancel) begin
         // Abort: results from the previous completed operation are left untouched.
         state <= IDLE;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (b == '0) begin
                     // Divide-by-zero resolves immediately with the architectural result.
                     state       <= DONE;
                     valid       <= 1'b1;
                     quotient    <= '1;
                     remainder   <= a;
                     div_by_zero <= 1'b1;
                  end else begin
                     state  <= RUN;
                     cnt    <= '0;
                     rem_r  <= '0;
                     quo_r  <= a_abs;
                     dvsr_r <= b_abs;
                     q_neg  <= a_neg ^ b_neg;
                     r_neg  <= a_neg;
                  end
               end
            end
            RUN: begin
               rem_r <= rem_nxt;
               quo_r <= quo_nxt;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(STEPS - 1)) begin
                  // Last iteration: publish the sign-corrected step outputs directly.
                  state       <= DONE;
                  valid       <= 1'b1;
                  quotient    <= q_neg ? -quo_nxt : quo_nxt;
                  remainder   <= r_neg ? -rem_nxt : rem_nxt;
                  div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: 32-bit radix-2 instance and 16-bit radix-16 instance.
// Stimulus pushes hand-computed results with the expected valid cycle; monitors pop on valid.
// Busy, cancel and reset behaviour are checked inline by the stimulus process.
module tb_div_unit;

   logic        clk;
   logic        rst;
   int          cyc;
   int          total;
   int          passed;

   logic        start32, sgn32, cancel32;
   logic [31:0] a32, b32;
   logic        busy32, valid32, dbz32;
   logic [31:0] quo32, rem32;

   logic        start16, sgn16, cancel16;
   logic [15:0] a16, b16;
   logic        busy16, valid16, dbz16;
   logic [15:0] quo16, rem16;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          cyc;
   } exp_t;

   exp_t        sb32[$];
   exp_t        sb16[$];
   logic [31:0] last_q32, last_r32;
   logic        last_dbz32;

   div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut32 (
      .clk         (clk),
      .rst         (rst),
      .start       (start32),
      .signed_i    (sgn32),
      .a           (a32),
      .b           (b32),
      .cancel      (cancel32),
      .busy        (busy32),
      .valid       (valid32),
      .quotient    (quo32),
      .remainder   (rem32),
      .div_by_zero (dbz32)
   );

   div_unit #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
      .clk         (clk),
      .rst         (rst),
      .start       (start16),
      .signed_i    (sgn16),
      .a           (a16),
      .b           (b16),
      .cancel      (cancel16),
      .busy        (busy16),
      .valid       (valid16),
      .quotient    (quo16),
      .remainder   (rem16),
      .div_by_zero (dbz16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end else begin
         passed++;
      end
   endtask

   // Monitors: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && valid32) begin
         if (sb32.size() == 0) begin
            chk("unexpected_valid32", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb32.pop_front();
            chk("quotient32",    quo32, e.q);
            chk("remainder32",   rem32, e.r);
            chk("div_by_zero32", dbz32, e.dbz);
            chk("latency32",     cyc,   e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (rst && valid16) begin
         if (sb16.size() == 0) begin
            chk("unexpected_valid16", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb16.pop_front();
            chk("quotient16",    {16'h0, quo16}, e.q);
            chk("remainder16",   {16'h0, rem16}, e.r);
            chk("div_by_zero16", dbz16,          e.dbz);
            chk("latency16",     cyc,            e.cyc);
         end
      end
   end

   // Issue one op on the 32-bit unit; checks busy every cycle up to and including DONE.
   // Operands are scrambled after the start cycle and stray starts are pulsed mid-run and in DONE.
   task automatic op32(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      int   lat;
      exp_t e;
      lat = (bv == 32'h0) ? 1 : 33;
      @(posedge clk); #1;
      a32 = av; b32 = bv; sgn32 = s; start32 = 1'b1;
      e.q = eq; e.r = er; e.dbz = edbz; e.cyc = cyc + lat;
      sb32.push_back(e);
      last_q32 = eq; last_r32 = er; last_dbz32 = edbz;
      for (int i = 0; i <= lat; i++) begin
         @(negedge clk);
         chk("busy32", busy32, (i < lat) ? 64'd1 : 64'd0);
         @(posedge clk); #1;
         a32 = $urandom; b32 = $urandom; sgn32 = ~sgn32;
         start32 = ((i == lat - 1) || (i == 2 && lat > 4)) ? 1'b1 : 1'b0;
      end
      start32 = 1'b0;
   endtask

   task automatic op16(input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz);
      int   lat;
      exp_t e;
      lat = (bv == 16'h0) ? 1 : 5;
      @(posedge clk); #1;
      a16 = av; b16 = bv; sgn16 = s; start16 = 1'b1;
      e.q = {16'h0, eq}; e.r = {16'h0, er}; e.dbz = edbz; e.cyc = cyc + lat;
      sb16.push_back(e);
      for (int i = 0; i <= lat; i++) begin
         @(negedge clk);
         chk("busy16", busy16, (i < lat) ? 64'd1 : 64'd0);
         @(posedge clk); #1;
         a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = ~sgn16;
         start16 = ((i == lat - 1) || (i == 2 && lat > 4)) ? 1'b1 : 1'b0;
      end
      start16 = 1'b0;
   endtask

   task automatic chk_results32(input string tag);
      chk({tag, "_quotient"},    quo32, last_q32);
      chk({tag, "_remainder"},   rem32, last_r32);
      chk({tag, "_div_by_zero"}, dbz32, last_dbz32);
   endtask

   initial begin
      total = 0; passed = 0;
      rst = 1'b0;
      start32 = 1'b1; sgn32 = 1'b0; cancel32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
      start16 = 1'b1; sgn16 = 1'b0; cancel16 = 1'b0; a16 = 16'd9;   b16 = 16'd0;
      last_q32 = 32'h0; last_r32 = 32'h0; last_dbz32 = 1'b0;

      // Reset held with start asserted: start must be ignored.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1; start32 = 1'b0; start16 = 1'b0;
      @(negedge clk);
      chk("reset_valid32", valid32, 64'd0);
      chk("reset_busy32",  busy32,  64'd0);
      chk_results32("reset");
      chk("reset_valid16",    valid16, 64'd0);
      chk("reset_quotient16", quo16,   64'd0);

      // Directed vectors with hand-computed results.
      op32(1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
      op32(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      op32(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0);
      op32(1'b0, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234,     1'b1);
      op32(1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0,        1'b0);
      op32(1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0);
      op32(1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0);
      op32(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2,        32'hFFFFFFFE, 1'b0);
      op32(1'b0, 32'd5,        32'd10,       32'd0,        32'd5,        1'b0);
      op32(1'b1, 32'hFFFFFF00, 32'h0,        32'hFFFFFFFF, 32'hFFFFFF00, 1'b1);

      // Cancel in RUN cycle 10: back to IDLE next cycle, no valid, prior results held.
      @(posedge clk); #1;
      a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0; start32 = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         start32  = 1'b0;
         cancel32 = (i == 10);
      end
      @(negedge clk);
      chk("cancel_busy32",  busy32,  64'd0);
      chk("cancel_valid32", valid32, 64'd0);
      chk_results32("cancel");
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk_results32("cancel_hold");

      op32(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);

      // Reset mid-RUN with start asserted in the reset cycle: operation discarded, outputs cleared.
      @(posedge clk); #1;
      a32 = 32'd100; b32 = 32'd7; sgn32 = 1'b0; start32 = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk); #1;
         rst     = (i != 6);
         start32 = (i == 6);
      end
      @(negedge clk);
      last_q32 = 32'h0; last_r32 = 32'h0; last_dbz32 = 1'b0;
      chk("rst_run_busy32",  busy32,  64'd0);
      chk("rst_run_valid32", valid32, 64'd0);
      chk_results32("rst_run");
      repeat (40) @(posedge clk);

      // 16-bit, four quotient bits per cycle.
      op16(1'b0, 16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 1'b0);
      op16(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
      op16(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
      op16(1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("sb32_drained", sb32.size(), 64'd0);
      chk("sb16_drained", sb16.size(), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", passed, total);
      $fatal(1);
   end

endmodule
